// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write unit: store-size
// codes and the request legality rule used at acceptance time.
package store_rmw_unit_pkg;

  localparam logic [1:0] STORE_B = 2'b00;
  localparam logic [1:0] STORE_H = 2'b01;
  localparam logic [1:0] STORE_W = 2'b10;

  // A request is rejected when its size is reserved or the address is not
  // naturally aligned for that size.
  function automatic logic is_rejected(input logic [1:0] size,
                                       input logic [1:0] addr_lo);
    case (size)
      STORE_B: is_rejected = 1'b0;
      STORE_H: is_rejected = addr_lo[0];
      STORE_W: is_rejected = (addr_lo != 2'b00);
      default: is_rejected = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_merge.sv
// Combinational lane merge: overlays the store data onto the word read
// back from DRAM, keeping every lane the store does not touch.
module store_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // Replace the addressed byte or half lane, pass the rest through.
  always_comb begin
    // NOTE: assigning the default first guarantees every path drives merged, so no latch is inferred.
    merged = word;
    case (size)
      STORE_B: merged[8*addr_lo +: 8] = wdata[7:0];
      STORE_H: begin
        if (addr_lo[1]) merged[31:16] = wdata;
        else            merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit in front of a word-only DRAM. Word stores are written
// directly; byte and half stores read the word, merge the new lane and
// write it back; misaligned or reserved requests are rejected.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        err,
  output logic [29:0] dram_adr,
  input  logic [31:0] dram_rdo,
  output logic        dram_we,
  output logic [31:0] dram_wdin
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

  state_t      state;
  logic [1:0]  rd_cnt;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic [15:0] wdata_q;
  logic [31:0] merged;

  // The merge sees live DRAM read data so the result is ready to capture
  // in the last READ cycle. Only the low half of wdata is ever merged; the
  // word path writes req_wdata straight through.
  store_merge u_merge (
    .word    (dram_rdo),
    .wdata   (wdata_q),
    .size    (size_q),
    .addr_lo (addr_lo_q),
    .merged  (merged)
  );

  // Control FSM; every output is registered alongside the state so each
  // output is a clean function of the state it belongs to.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      addr_lo_q <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      dram_we   <= 1'b0;
      dram_adr  <= '0;
      dram_wdin <= '0;
    end else begin
      // NOTE: non-blocking assignments let the later case arms override these pulse defaults without ordering races.
      done    <= 1'b0;
      err     <= 1'b0;
      dram_we <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo_q <= req_addr[1:0];
            size_q    <= req_size;
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (is_rejected(req_size, req_addr[1:0])) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (req_size == STORE_W) begin
              state     <= WRITE;
              dram_adr  <= req_addr[31:2];
              dram_we   <= 1'b1;
              dram_wdin <= req_wdata;
              done      <= 1'b1;
            end else begin
              state    <= READ;
              dram_adr <= req_addr[31:2];
              rd_cnt   <= 2'(RD_LAT - 1);
            end
          end
        end

        READ: begin
          if (rd_cnt == 2'd0) begin
            state     <= WRITE;
            dram_we   <= 1'b1;
            dram_wdin <= merged;
            done      <= 1'b1;
          end else begin
            rd_cnt <= rd_cnt - 2'd1;
          end
        end

        WRITE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          dram_adr  <= '0;
          dram_wdin <= '0;
        end

        ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          dram_adr  <= '0;
          dram_wdin <= '0;
        end
      endcase
    end
  end

endmodule
